writeback: RTL and testbench

- Final pipeline stage and the write-side counterpart of the operand-read stage.
- Owns the single register-file write port and merges three result sources into it: ALU results, memory load results, and link (return-address) writes.
- Link writes split a 31-bit PC into a lo/hi register pair. The lo register holds {pc[14:0],1'b0} and the hi register holds pc[30:15], which is exactly the layout the read stage reassembles when jumping through registers.
- Maintains a pending-write scoreboard. The read stage uses it to stall on RAW hazards.

---
 rtl/browar_pkg.sv | 31 +++
 rtl/wb_scoreboard.sv | 37 +++
 rtl/writeback.sv | 142 ++++++++++++++
 tb/tb_writeback.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/browar_pkg.sv
// Shared types and sizing for the writeback stage and its pending-write scoreboard.
// Link writes split a PC into a lo half {pc[DATA_W-2:0],1'b0} and a hi half pc[PC_W-1:DATA_W-1].
package browar_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int REG_N  = 16;
    localparam int PC_W   = 31;

    typedef enum logic {
        WB_IDLE,
        WB_LINK_HI
    } wb_state_t;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_MEM,
        SRC_LINK_LO,
        SRC_LINK_HI
    } wb_src_t;

    function automatic logic [DATA_W-1:0] link_lo_half(input logic [PC_W-1:0] pc);
        return {pc[DATA_W-2:0], 1'b0};
    endfunction

    function automatic logic [DATA_W-1:0] link_hi_half(input logic [PC_W-1:0] pc);
        return pc[PC_W-1:DATA_W-1];
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write bitmask: a completed write clears its bit, a decode claim sets one.
// When both hit the same register in one cycle the claim wins.
module wb_scoreboard
    import browar_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_valid,
    input  logic [ADDR_W-1:0] clr_reg,
    input  logic              set_valid,
    input  logic [ADDR_W-1:0] set_reg,
    output logic [REG_N-1:0]  pending
);

    logic [REG_N-1:0] r_pending;
    logic [REG_N-1:0] w_clr_mask;
    logic [REG_N-1:0] w_set_mask;

    always_comb begin
        w_clr_mask = '0;
        w_set_mask = '0;
        if (clr_valid) w_clr_mask[clr_reg] = 1'b1;
        if (set_valid) w_set_mask[set_reg] = 1'b1;
    end

    // Set is OR-ed after the clear so a same-register claim survives the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign pending = r_pending;

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: arbitrates ALU, load and two-beat link writes onto the single
// register-file write port, and tracks outstanding destinations for RAW stalls upstream.
module writeback
    import browar_pkg::*;
(
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dst,
    input  logic [DATA_W-1:0] alu_value,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_value,
    input  logic              link_valid,
    output logic              link_ready,
    input  logic [ADDR_W-1:0] link_dst_lo,
    input  logic [ADDR_W-1:0] link_dst_hi,
    input  logic [PC_W-1:0]   link_pc,
    input  logic              claim_valid,
    input  logic [ADDR_W-1:0] claim_reg,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [REG_N-1:0]  pending,
    output logic              wb_stall,
    output wb_state_t         dbg_state
);

    // Handshake: mem_ready/link_ready are combinational accepts, high only in the cycle
    // the matching valid is taken; ALU results have no ready and are always taken.

    wb_state_t         r_state;
    wb_state_t         w_next_state;
    wb_src_t           w_src;
    logic [ADDR_W-1:0] r_hi_dst;
    logic [DATA_W-1:0] r_hi_data;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    always_comb begin
        w_next_state = r_state;
        w_src        = SRC_NONE;
        link_ready   = 1'b0;
        mem_ready    = 1'b0;
        case (r_state)
            WB_IDLE: begin
                if (alu_valid) begin
                    w_src = SRC_ALU;
                end else if (link_valid) begin
                    w_src        = SRC_LINK_LO;
                    link_ready   = 1'b1;
                    w_next_state = WB_LINK_HI;
                end else if (mem_valid) begin
                    w_src     = SRC_MEM;
                    mem_ready = 1'b1;
                end
            end
            WB_LINK_HI: begin
                // A late ALU result still owns the port; the hi half waits behind it.
                if (alu_valid) begin
                    w_src = SRC_ALU;
                end else begin
                    w_src        = SRC_LINK_HI;
                    w_next_state = WB_IDLE;
                end
            end
            default: w_next_state = WB_IDLE;
        endcase
        if (!cpu_rst) begin
            link_ready = 1'b0;
            mem_ready  = 1'b0;
        end
    end

    always_comb begin
        w_waddr = '0;
        w_wdata = '0;
        case (w_src)
            SRC_ALU: begin
                w_waddr = alu_dst;
                w_wdata = alu_value;
            end
            SRC_MEM: begin
                w_waddr = mem_dst;
                w_wdata = mem_value;
            end
            SRC_LINK_LO: begin
                w_waddr = link_dst_lo;
                w_wdata = link_lo_half(link_pc);
            end
            SRC_LINK_HI: begin
                w_waddr = r_hi_dst;
                w_wdata = r_hi_data;
            end
            default: begin
                w_waddr = '0;
                w_wdata = '0;
            end
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            r_state   <= WB_IDLE;
            r_hi_dst  <= '0;
            r_hi_data <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_src == SRC_LINK_LO) begin
                r_hi_dst  <= link_dst_hi;
                r_hi_data <= link_hi_half(link_pc);
            end
            r_we    <= (w_src != SRC_NONE);
            r_waddr <= w_waddr;
            r_wdata <= w_wdata;
        end
    end

    wb_scoreboard u_scoreboard (
        .clk       (cpu_clk),
        .rst_n     (cpu_rst),
        .clr_valid (r_we),
        .clr_reg   (r_waddr),
        .set_valid (claim_valid),
        .set_reg   (claim_reg),
        .pending   (pending)
    );

    assign rf_we     = r_we;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;
    assign wb_stall  = (r_state == WB_LINK_HI) || link_ready;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_writeback.sv
// Directed and randomized bench for writeback against a queue-based reference model.
// The model tracks outstanding hi halves and expected port words, not the RTL state machine.
module tb_writeback;
    import browar_pkg::*;

    localparam int W = 1 + ADDR_W + DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } hi_ent_t;

    logic              cpu_clk;
    logic              cpu_rst;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_dst;
    logic [DATA_W-1:0] alu_value;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_dst;
    logic [DATA_W-1:0] mem_value;
    logic              link_valid;
    logic              link_ready;
    logic [ADDR_W-1:0] link_dst_lo;
    logic [ADDR_W-1:0] link_dst_hi;
    logic [PC_W-1:0]   link_pc;
    logic              claim_valid;
    logic [ADDR_W-1:0] claim_reg;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [REG_N-1:0]  pending;
    logic              wb_stall;
    wb_state_t         dbg_state;

    writeback dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .alu_valid   (alu_valid),
        .alu_dst     (alu_dst),
        .alu_value   (alu_value),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_dst     (mem_dst),
        .mem_value   (mem_value),
        .link_valid  (link_valid),
        .link_ready  (link_ready),
        .link_dst_lo (link_dst_lo),
        .link_dst_hi (link_dst_hi),
        .link_pc     (link_pc),
        .claim_valid (claim_valid),
        .claim_reg   (claim_reg),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .pending     (pending),
        .wb_stall    (wb_stall),
        .dbg_state   (dbg_state)
    );

    // Clock and reset
    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // Scoreboard state
    int               checks = 0;
    int               errors = 0;
    logic [W-1:0]     exp_q[$];
    hi_ent_t          hi_q[$];
    logic [REG_N-1:0] m_pend = '0;
    logic [W-1:0]     last_w = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_rst     = 1'b1;
        alu_valid   = 1'b0;
        alu_dst     = '0;
        alu_value   = '0;
        mem_valid   = 1'b0;
        mem_dst     = '0;
        mem_value   = '0;
        link_valid  = 1'b0;
        link_dst_lo = '0;
        link_dst_hi = '0;
        link_pc     = '0;
        claim_valid = 1'b0;
        claim_reg   = '0;
    endtask

    // Advance one clock with the inputs currently driven, checking both sides of the edge.
    task automatic cycle();
        bit           busy;
        bit           exp_lr;
        bit           exp_mr;
        logic [W-1:0] nxt;
        logic [W-1:0] got;
        hi_ent_t      e;
        int unsigned  pc;
        #1;
        busy   = (hi_q.size() != 0);
        exp_lr = cpu_rst && !busy && !alu_valid && link_valid;
        exp_mr = cpu_rst && !busy && !alu_valid && !link_valid && mem_valid;
        check("link_ready", link_ready, exp_lr);
        check("mem_ready", mem_ready, exp_mr);
        check("wb_stall", wb_stall, busy || exp_lr);
        check("state", dbg_state, busy ? WB_LINK_HI : WB_IDLE);

        if (!cpu_rst) begin
            nxt    = '0;
            m_pend = '0;
            hi_q.delete();
        end else begin
            if (last_w[W-1]) m_pend[last_w[W-2:DATA_W]] = 1'b0;
            if (claim_valid) m_pend[claim_reg] = 1'b1;
            pc = int'(link_pc);
            if (alu_valid) begin
                nxt = {1'b1, alu_dst, alu_value};
            end else if (busy) begin
                e   = hi_q.pop_front();
                nxt = {1'b1, e.dst, e.data};
            end else if (link_valid) begin
                nxt = {1'b1, link_dst_lo, DATA_W'((pc % 32768) * 2)};
                e.dst  = link_dst_hi;
                e.data = DATA_W'(pc / 32768);
                hi_q.push_back(e);
            end else if (mem_valid) begin
                nxt = {1'b1, mem_dst, mem_value};
            end else begin
                nxt = '0;
            end
        end
        exp_q.push_back(nxt);
        last_w = nxt;

        @(posedge cpu_clk);
        #1;
        got = exp_q.pop_front();
        check("rf_we", rf_we, got[W-1]);
        if (got[W-1]) begin
            check("rf_waddr", rf_waddr, got[W-2:DATA_W]);
            check("rf_wdata", rf_wdata, got[DATA_W-1:0]);
        end else if (!cpu_rst) begin
            check("rst_waddr", rf_waddr, 0);
            check("rst_wdata", rf_wdata, 0);
        end
        check("pending", pending, m_pend);
    endtask

    initial begin
        idle_inputs();

        // Reset
        cpu_rst = 1'b0;
        cycle();
        cycle();
        check("reset_pending", pending, 0);
        check("reset_rf_we", rf_we, 0);

        // ALU only
        idle_inputs();
        alu_valid = 1'b1; alu_dst = 4'd3; alu_value = 16'hBEEF;
        cycle();
        check("alu_addr_const", rf_waddr, 3);
        check("alu_data_const", rf_wdata, 16'hBEEF);
        idle_inputs();
        cycle();
        check("alu_then_idle", rf_we, 0);

        // ALU and load collide
        alu_valid = 1'b1; alu_dst = 4'd2; alu_value = 16'h1111;
        mem_valid = 1'b1; mem_dst = 4'd5; mem_value = 16'h2222;
        #1;
        check("collide_mem_ready0", mem_ready, 0);
        cycle();
        check("collide_r2", rf_waddr, 2);
        alu_valid = 1'b0;
        #1;
        check("collide_mem_ready1", mem_ready, 1);
        cycle();
        check("collide_r5", rf_waddr, 5);
        check("collide_r5_data", rf_wdata, 16'h2222);
        idle_inputs();
        cycle();

        // Link
        link_valid = 1'b1; link_pc = 31'h1234_5678; link_dst_lo = 4'd6; link_dst_hi = 4'd7;
        cycle();
        check("link_lo_addr", rf_waddr, 6);
        check("link_lo_data", rf_wdata, 16'hACF0);
        idle_inputs();
        cycle();
        check("link_hi_addr", rf_waddr, 7);
        check("link_hi_data", rf_wdata, 16'h2468);
        cycle();
        check("link_done_stall", wb_stall, 0);

        // Link interrupted by an in-flight ALU result
        link_valid = 1'b1; link_pc = 31'h7FFF_FFFF; link_dst_lo = 4'd1; link_dst_hi = 4'd8;
        cycle();
        idle_inputs();
        alu_valid = 1'b1; alu_dst = 4'd9; alu_value = 16'h5555;
        cycle();
        check("intr_alu_first", rf_waddr, 9);
        idle_inputs();
        #1;
        check("intr_stall_held", wb_stall, 1);
        cycle();
        check("intr_hi_after", rf_waddr, 8);
        check("intr_hi_data", rf_wdata, 16'hFFFF);
        cycle();

        // Scoreboard claim-wins
        claim_valid = 1'b1; claim_reg = 4'd4;
        cycle();
        check("sb_claim", pending[4], 1);
        idle_inputs();
        alu_valid = 1'b1; alu_dst = 4'd4; alu_value = 16'h0404;
        cycle();
        idle_inputs();
        alu_valid = 1'b1; alu_dst = 4'd4; alu_value = 16'h0444;
        claim_valid = 1'b1; claim_reg = 4'd4;
        cycle();
        check("sb_claim_wins", pending[4], 1);
        idle_inputs();
        cycle();
        check("sb_cleared", pending[4], 0);

        // Reset mid-link
        link_valid = 1'b1; link_pc = 31'h0ABC_DEF1; link_dst_lo = 4'd10; link_dst_hi = 4'd11;
        claim_valid = 1'b1; claim_reg = 4'd11;
        cycle();
        idle_inputs();
        cpu_rst = 1'b0;
        cycle();
        check("midlink_we", rf_we, 0);
        check("midlink_pending", pending, 0);
        check("midlink_state", dbg_state, WB_IDLE);
        idle_inputs();
        cycle();
        check("midlink_no_hi", rf_we, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cpu_rst     = ($urandom_range(0, 49) != 0);
            alu_valid   = ($urandom_range(0, 3) == 0);
            alu_dst     = ADDR_W'($urandom_range(0, REG_N - 1));
            alu_value   = DATA_W'($urandom);
            mem_valid   = ($urandom_range(0, 1) == 0);
            mem_dst     = ADDR_W'($urandom_range(0, REG_N - 1));
            mem_value   = DATA_W'($urandom);
            link_valid  = ($urandom_range(0, 3) == 0);
            link_dst_lo = ADDR_W'($urandom_range(0, REG_N - 1));
            link_dst_hi = ($urandom_range(0, 7) == 0) ? link_dst_lo
                                                      : ADDR_W'($urandom_range(0, REG_N - 1));
            link_pc     = PC_W'($urandom);
            claim_valid = ($urandom_range(0, 1) == 0);
            claim_reg   = ADDR_W'($urandom_range(0, REG_N - 1));
            cycle();
        end
        idle_inputs();
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
